// File: rtl/lc3_rf_pkg.sv
// Shared types and constants for the LC-3 register file: widths, sequencer
// states, and the NZP condition-code encodings.
`timescale 1ns/1ps
package lc3_rf_pkg;

   localparam int REG_W = 16;
   localparam int NREG  = 8;
   localparam int SEL_W = 3;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      CLEAR = 1'b1
   } rf_state_e;

   localparam logic [2:0] CC_N = 3'b100;
   localparam logic [2:0] CC_Z = 3'b010;
   localparam logic [2:0] CC_P = 3'b001;

   // Exactly one of N/Z/P is set for any value.
   function automatic logic [2:0] cc_of(input logic [REG_W-1:0] v);
      if (v[REG_W-1])
         return CC_N;
      else if (v == '0)
         return CC_Z;
      else
         return CC_P;
   endfunction

endpackage

// File: rtl/mux_8_1_bit_16.sv
// 8:1 multiplexer of 16-bit words; the eight inputs arrive concatenated,
// entry 0 in the least-significant slice.
`timescale 1ns/1ps
module mux_8_1_bit_16 (
   input  logic [127:0] data_i,
   input  logic [2:0]   sel_i,
   output logic [15:0]  data_o
);

   assign data_o = data_i[{sel_i, 4'b0000} +: 16];

endmodule

// File: rtl/lc3_reg_file.sv
// LC-3 R0-R7 register file with NZP flags, two live read ports and a
// one-register-per-cycle soft-clear sweep. Optional macro: REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module lc3_reg_file
   import lc3_rf_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [2:0]  wb_dr,
   input  logic [15:0] wb_data,
   input  logic        wb_set_cc,
   input  logic        clr,
   input  logic [2:0]  sr1_sel,
   input  logic [2:0]  sr2_sel,
   output logic [15:0] sr1_data,
   output logic [15:0] sr2_data,
   output logic [2:0]  nzp,
   output logic        busy
);

   rf_state_e          state_q, state_d;
   logic [SEL_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         nzp_q, nzp_d;
   logic [REG_W-1:0]   regs_q [NREG];
   logic [REG_W-1:0]   regs_d [NREG];
   logic [NREG*REG_W-1:0] regs_flat;
   logic [REG_W-1:0]   mux1_out, mux2_out;
   logic               accept;

   // clr wins over a same-cycle write so the requester simply holds it.
   assign wb_ready = (state_q == RUN) && !clr;
   assign busy     = (state_q == CLEAR);
   assign accept   = wb_valid && wb_ready;
   assign nzp      = nzp_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nzp_d   = nzp_q;
      regs_d  = regs_q;
      case (state_q)
         RUN: begin
            if (accept) begin
               regs_d[wb_dr] = wb_data;
               if (wb_set_cc)
                  nzp_d = cc_of(wb_data);
            end
            if (clr)
               state_d = CLEAR;
         end
         CLEAR: begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = RUN;
               nzp_d   = CC_Z;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         nzp_q   <= CC_Z;
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nzp_q   <= nzp_d;
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= regs_d[i];
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < NREG; i++)
         regs_flat[i*REG_W +: REG_W] = regs_q[i];
   end

   mux_8_1_bit_16 u_mux_sr1 (
      .data_i (regs_flat),
      .sel_i  (sr1_sel),
      .data_o (mux1_out)
   );

   mux_8_1_bit_16 u_mux_sr2 (
      .data_i (regs_flat),
      .sel_i  (sr2_sel),
      .data_o (mux2_out)
   );

`ifdef REGFILE_BYPASS_EN
   // Forward the accepted write to a port reading the same register.
   assign sr1_data = (accept && (sr1_sel == wb_dr)) ? wb_data : mux1_out;
   assign sr2_data = (accept && (sr2_sel == wb_dr)) ? wb_data : mux2_out;
`else
   assign sr1_data = mux1_out;
   assign sr2_data = mux2_out;
`endif

endmodule

// File: tb/tb_lc3_reg_file.sv
// Scoreboard bench for lc3_reg_file: expectations are queued as stimulus is
// driven and compared against the DUT outputs once they settle.
`timescale 1ns/1ps
module tb_lc3_reg_file;

   localparam int SIG_SR1  = 0;
   localparam int SIG_SR2  = 1;
   localparam int SIG_NZP  = 2;
   localparam int SIG_RDY  = 3;
   localparam int SIG_BUSY = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [2:0]  wb_dr;
   logic [15:0] wb_data;
   logic        wb_set_cc;
   logic        clr;
   logic [2:0]  sr1_sel;
   logic [2:0]  sr2_sel;
   logic [15:0] sr1_data;
   logic [15:0] sr2_data;
   logic [2:0]  nzp;
   logic        busy;

   always #5 clk = ~clk;

   lc3_reg_file dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_dr     (wb_dr),
      .wb_data   (wb_data),
      .wb_set_cc (wb_set_cc),
      .clr       (clr),
      .sr1_sel   (sr1_sel),
      .sr2_sel   (sr2_sel),
      .sr1_data  (sr1_data),
      .sr2_data  (sr2_data),
      .nzp       (nzp),
      .busy      (busy)
   );

   typedef struct {
      string       tag;
      int          sig;
      logic [15:0] exp;
   } exp_t;

   exp_t expq[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic [15:0] fill_val [8];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] observe(input int sig);
      case (sig)
         SIG_SR1:  return sr1_data;
         SIG_SR2:  return sr2_data;
         SIG_NZP:  return {13'b0, nzp};
         SIG_RDY:  return {15'b0, wb_ready};
         default:  return {15'b0, busy};
      endcase
   endfunction

   task automatic push(input string tag, input int sig, input logic [15:0] exp);
      exp_t it;
      it.tag = tag;
      it.sig = sig;
      it.exp = exp;
      expq.push_back(it);
   endtask

   task automatic drain();
      exp_t it;
      #1;
      while (expq.size() > 0) begin
         it = expq.pop_front();
         check(it.tag, observe(it.sig), it.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] dr, input logic [15:0] data, input logic cc);
      wb_valid  = 1'b1;
      wb_dr     = dr;
      wb_data   = data;
      wb_set_cc = cc;
      push("wr_ready", SIG_RDY, 16'h1);
      drain();
      tick();
      wb_valid  = 1'b0;
      wb_set_cc = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; wb_valid = 1'b0; wb_dr = '0; wb_data = '0; wb_set_cc = 1'b0;
      clr = 1'b0; sr1_sel = '0; sr2_sel = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      push("rst_nzp", SIG_NZP, 16'h2);
      push("rst_ready", SIG_RDY, 16'h1);
      push("rst_busy", SIG_BUSY, 16'h0);
      drain();
      for (int i = 0; i < 8; i++) begin
         sr1_sel = 3'(i);
         sr2_sel = 3'(7 - i);
         push("rst_sr1", SIG_SR1, 16'h0);
         push("rst_sr2", SIG_SR2, 16'h0);
         drain();
      end

      // Condition codes
      wr(3'd3, 16'h8001, 1'b1);
      sr1_sel = 3'd3;
      push("r3_read", SIG_SR1, 16'h8001);
      push("cc_neg", SIG_NZP, 16'h4);
      drain();
      wr(3'd5, 16'h0000, 1'b1);
      push("cc_zero", SIG_NZP, 16'h2);
      drain();
      wr(3'd7, 16'h0001, 1'b1);
      push("cc_pos", SIG_NZP, 16'h1);
      drain();
      wr(3'd6, 16'hFFFF, 1'b1);
      push("cc_neg2", SIG_NZP, 16'h4);
      drain();
      wr(3'd2, 16'h1234, 1'b0);
      sr2_sel = 3'd2;
      push("cc_hold", SIG_NZP, 16'h4);
      push("r2_read", SIG_SR2, 16'h1234);
      sr1_sel = 3'd7;
      push("r7_read", SIG_SR1, 16'h0001);
      drain();

      // Same-cycle write/read of R4, both ports on different registers
      sr1_sel = 3'd3;
      sr2_sel = 3'd4;
      wb_valid = 1'b1; wb_dr = 3'd4; wb_data = 16'hBEEF; wb_set_cc = 1'b0;
`ifdef REGFILE_BYPASS_EN
      push("bypass_sr2", SIG_SR2, 16'hBEEF);
`else
      push("nobypass_sr2", SIG_SR2, 16'h0000);
`endif
      push("bypass_sr1_other", SIG_SR1, 16'h8001);
      push("bypass_nzp", SIG_NZP, 16'h4);
      drain();
      tick();
      wb_valid = 1'b0;
      push("r4_after", SIG_SR2, 16'hBEEF);
      sr1_sel = 3'd4;
      push("same_reg_both", SIG_SR1, 16'hBEEF);
      drain();

      // Fill, then clear sweep with a held write
      for (int i = 0; i < 8; i++) begin
         fill_val[i] = 16'((i + 1) * 16'h0011);
         wr(3'(i), fill_val[i], 1'b0);
      end
      wb_valid = 1'b1; wb_dr = 3'd1; wb_data = 16'h5555; wb_set_cc = 1'b1;
      clr = 1'b1;
      push("clr_ready", SIG_RDY, 16'h0);
      push("clr_busy_pre", SIG_BUSY, 16'h0);
      drain();
      tick();
      clr = 1'b0;
      for (int c = 0; c < 8; c++) begin
         clr = (c >= 2 && c <= 4);
         sr1_sel = 3'(c);
         push("sweep_busy", SIG_BUSY, 16'h1);
         push("sweep_ready", SIG_RDY, 16'h0);
         push("sweep_pending", SIG_SR1, fill_val[c]);
         if (c > 0) begin
            sr2_sel = 3'(c - 1);
            push("sweep_cleared", SIG_SR2, 16'h0000);
         end else begin
            sr2_sel = 3'd7;
            push("sweep_last_intact", SIG_SR2, fill_val[7]);
         end
         drain();
         tick();
      end
      clr = 1'b0;
      sr1_sel = 3'd0;
      sr2_sel = 3'd7;
      push("post_busy", SIG_BUSY, 16'h0);
      push("post_ready", SIG_RDY, 16'h1);
      push("post_nzp", SIG_NZP, 16'h2);
      push("post_r0", SIG_SR1, 16'h0000);
      push("post_r7", SIG_SR2, 16'h0000);
      drain();
      tick();
      wb_valid = 1'b0; wb_set_cc = 1'b0;
      sr1_sel = 3'd1;
      push("held_write", SIG_SR1, 16'h5555);
      push("held_write_cc", SIG_NZP, 16'h1);
      drain();

      // Reset in the middle of a sweep
      wr(3'd5, 16'hFFFF, 1'b1);
      wr(3'd2, 16'h0ABC, 1'b0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (4) tick();
      sr1_sel = 3'd5;
      sr2_sel = 3'd2;
      push("mid_busy", SIG_BUSY, 16'h1);
      push("mid_r5", SIG_SR1, 16'hFFFF);
      push("mid_r2", SIG_SR2, 16'h0000);
      push("mid_nzp", SIG_NZP, 16'h4);
      drain();
      rst_n = 1'b0;
      push("arst_busy", SIG_BUSY, 16'h0);
      push("arst_r5", SIG_SR1, 16'h0000);
      push("arst_nzp", SIG_NZP, 16'h2);
      drain();
      sr1_sel = 3'd1;
      push("arst_r1", SIG_SR1, 16'h0000);
      drain();
      tick();
      rst_n = 1'b1;
      push("rel_ready", SIG_RDY, 16'h1);
      push("rel_busy", SIG_BUSY, 16'h0);
      drain();
      wr(3'd6, 16'h7777, 1'b1);
      sr2_sel = 3'd6;
      push("rel_write", SIG_SR2, 16'h7777);
      push("rel_cc", SIG_NZP, 16'h1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
